// File: rtl/sccb_arb_pkg.sv
// Shared types for the two-port SCCB arbiter.
// FSM encoding, request op codes and port indices.
package sccb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } op_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int CNT_W = 16;

endpackage

// File: rtl/sccb_arb_slot.sv
// One-entry request buffer in front of the shared SCCB master.
// Holds {op, addr, wdata} from the request pulse until the arbiter clears it.
module sccb_arb_slot
    import sccb_arb_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr,
    output logic              rdy,
    output logic              pending,
    output logic              rd_op,
    output logic [DATA_W-1:0] addr_q,
    output logic [DATA_W-1:0] wdata_q
);

    op_t op_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
            op_q    <= OP_WR;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (clr) begin
            pending <= 1'b0;
        end else if (!pending && (wr_en || rd_en)) begin
            // A write wins when both strobes arrive together.
            pending <= 1'b1;
            op_q    <= wr_en ? OP_WR : OP_RD;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    assign rdy   = !pending;
    assign rd_op = (op_q == OP_RD);

endmodule

// File: rtl/sccb_arbiter.sv
// Two-port arbiter sharing one SCCB master between the OV7670
// config sequencer (port 0) and a runtime tuning requester (port 1).
module sccb_arbiter
    import sccb_arb_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 65535,
    parameter int RR      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_wr_en,
    input  logic              m0_rd_en,
    input  logic [DATA_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic              m0_rdy,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rdata_vld,
    output logic              m0_err,
    input  logic              m1_wr_en,
    input  logic              m1_rd_en,
    input  logic [DATA_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_rdy,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rdata_vld,
    output logic              m1_err,
    output logic              s_wr_en,
    output logic              s_rd_en,
    output logic [DATA_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic              s_rdy,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_rdata_vld,
    output logic              owner,
    output logic              busy
);

    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);

    state_t state;
    state_t state_d;

    logic              pend0, pend1;
    logic              rd0, rd1;
    logic [DATA_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              clr0, clr1;

    logic              grant_vld;
    logic              grant_id;
    logic              grant_rd;
    logic [DATA_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wdata;

    logic [CNT_W-1:0]  cnt;
    logic              tmo;
    logic              done;
    logic              abort;
    logic              lock_q;
    logic              lock_d;
    logic              owner_lock;
    logic              owner_pend;
    logic              fwd;

    sccb_arb_slot #(.DATA_W(DATA_W)) u_slot0 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (m0_wr_en),
        .rd_en   (m0_rd_en),
        .addr    (m0_addr),
        .wdata   (m0_wdata),
        .clr     (clr0),
        .rdy     (m0_rdy),
        .pending (pend0),
        .rd_op   (rd0),
        .addr_q  (addr0),
        .wdata_q (wdata0)
    );

    sccb_arb_slot #(.DATA_W(DATA_W)) u_slot1 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (m1_wr_en),
        .rd_en   (m1_rd_en),
        .addr    (m1_addr),
        .wdata   (m1_wdata),
        .clr     (clr1),
        .rdy     (m1_rdy),
        .pending (pend1),
        .rd_op   (rd1),
        .addr_q  (addr1),
        .wdata_q (wdata1)
    );

    assign owner_lock = (owner == PORT1) ? m1_lock : m0_lock;
    assign owner_pend = (owner == PORT1) ? pend1 : pend0;
    assign tmo        = (cnt == TMO_VAL);
    assign busy       = (state != IDLE);
    assign fwd        = s_rdata_vld && (state != IDLE);

    // Grant selection; a held lock restricts eligibility to the owner.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = owner;
        if (state == IDLE && s_rdy) begin
            if (lock_q && owner_lock) begin
                grant_vld = owner_pend;
            end else if (pend0 && pend1) begin
                grant_vld = 1'b1;
                grant_id  = (RR != 0) ? ~owner : PORT0;
            end else if (pend0) begin
                grant_vld = 1'b1;
                grant_id  = PORT0;
            end else if (pend1) begin
                grant_vld = 1'b1;
                grant_id  = PORT1;
            end
        end
    end

    always_comb begin
        grant_rd    = rd0;
        grant_addr  = addr0;
        grant_wdata = wdata0;
        if (grant_id == PORT1) begin
            grant_rd    = rd1;
            grant_addr  = addr1;
            grant_wdata = wdata1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        done    = 1'b0;
        abort   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tmo) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (!s_rdy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (s_rdy) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (tmo) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign clr0 = (done || abort) && (owner == PORT0);
    assign clr1 = (done || abort) && (owner == PORT1);

    always_comb begin
        lock_d = lock_q;
        if (abort) begin
            lock_d = 1'b0;
        end else if (done) begin
            lock_d = owner_lock;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_wr_en      <= 1'b0;
            s_rd_en      <= 1'b0;
            s_addr       <= '0;
            s_wdata      <= '0;
            owner        <= PORT0;
            cnt          <= '0;
            lock_q       <= 1'b0;
            m0_rdata_vld <= 1'b0;
            m1_rdata_vld <= 1'b0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
            m0_err       <= 1'b0;
            m1_err       <= 1'b0;
        end else begin
            s_wr_en      <= grant_vld && !grant_rd;
            s_rd_en      <= grant_vld && grant_rd;
            lock_q       <= lock_d;
            m0_rdata_vld <= fwd && (owner == PORT0);
            m1_rdata_vld <= fwd && (owner == PORT1);
            m0_err       <= abort && (owner == PORT0);
            m1_err       <= abort && (owner == PORT1);
            if (grant_vld) begin
                s_addr  <= grant_addr;
                s_wdata <= grant_wdata;
                owner   <= grant_id;
                cnt     <= '0;
            end else if (state != IDLE) begin
                cnt <= cnt + 1'b1;
            end
            if (fwd && owner == PORT0) begin
                m0_rdata <= s_rdata;
            end
            if (fwd && owner == PORT1) begin
                m1_rdata <= s_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sccb_arbiter.sv
// Directed bench: two arbiters (RR=1 and RR=0, TIMEOUT=20) on shared
// requester inputs, each with its own behavioural SCCB master.
module tb_sccb_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       m0_wr_en = 0, m0_rd_en = 0, m0_lock = 0;
    logic       m1_wr_en = 0, m1_rd_en = 0, m1_lock = 0;
    logic [7:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;

    logic       m0_rdy[2], m1_rdy[2], m0_rdata_vld[2], m1_rdata_vld[2];
    logic       m0_err[2], m1_err[2], s_wr_en[2], s_rd_en[2];
    logic       s_rdy[2], s_rdata_vld[2], owner[2], busy[2];
    logic [7:0] m0_rdata[2], m1_rdata[2], s_addr[2], s_wdata[2], s_rdata[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sccb_arbiter #(.DATA_W(8), .TIMEOUT(20), .RR(g == 0 ? 1 : 0)) dut (
            .clk(clk), .rst(rst),
            .m0_wr_en(m0_wr_en), .m0_rd_en(m0_rd_en), .m0_addr(m0_addr),
            .m0_wdata(m0_wdata), .m0_lock(m0_lock), .m0_rdy(m0_rdy[g]),
            .m0_rdata(m0_rdata[g]), .m0_rdata_vld(m0_rdata_vld[g]),
            .m0_err(m0_err[g]),
            .m1_wr_en(m1_wr_en), .m1_rd_en(m1_rd_en), .m1_addr(m1_addr),
            .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_rdy(m1_rdy[g]),
            .m1_rdata(m1_rdata[g]), .m1_rdata_vld(m1_rdata_vld[g]),
            .m1_err(m1_err[g]),
            .s_wr_en(s_wr_en[g]), .s_rd_en(s_rd_en[g]), .s_addr(s_addr[g]),
            .s_wdata(s_wdata[g]), .s_rdy(s_rdy[g]), .s_rdata(s_rdata[g]),
            .s_rdata_vld(s_rdata_vld[g]), .owner(owner[g]), .busy(busy[g])
        );
    end

    typedef struct packed {
        logic [31:0] cyc;
        logic        rd;
        logic [7:0]  addr;
        logic [7:0]  wdata;
    } iss_t;

    int         cyc = 0;
    int         lat = 3;
    logic       hang = 1'b0;
    logic [7:0] rsp = 8'h00;

    iss_t ilog[2][64];
    int   dlog[2][64];
    int   icnt[2] = '{0, 0};
    int   dcnt[2] = '{0, 0};
    int   mcnt[2];
    logic mrd[2];
    int   vcnt[2][2] = '{'{0, 0}, '{0, 0}};
    int   vcyc[2][2];
    logic [7:0] vdat[2][2];
    int   ecnt[2][2] = '{'{0, 0}, '{0, 0}};

    // Behavioural SCCB masters plus event recorders for both instances.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            s_rdata_vld[i] <= 1'b0;
            if (rst) begin
                s_rdy[i]   <= 1'b1;
                mcnt[i]    <= 0;
                mrd[i]     <= 1'b0;
                s_rdata[i] <= 8'h00;
            end else if (s_wr_en[i] || s_rd_en[i]) begin
                if (icnt[i] < 64)
                    ilog[i][icnt[i]] <= '{cyc, s_rd_en[i], s_addr[i], s_wdata[i]};
                icnt[i]  <= icnt[i] + 1;
                s_rdy[i] <= 1'b0;
                mcnt[i]  <= lat;
                mrd[i]   <= s_rd_en[i];
            end else if (!s_rdy[i] && !hang) begin
                if (mcnt[i] == 0) begin
                    s_rdy[i]       <= 1'b1;
                    s_rdata_vld[i] <= mrd[i];
                    s_rdata[i]     <= rsp;
                    if (dcnt[i] < 64) dlog[i][dcnt[i]] <= cyc + 1;
                    dcnt[i] <= dcnt[i] + 1;
                end else begin
                    mcnt[i] <= mcnt[i] - 1;
                end
            end
            if (m0_rdata_vld[i]) begin
                vcnt[i][0] <= vcnt[i][0] + 1;
                vcyc[i][0] <= cyc;
                vdat[i][0] <= m0_rdata[i];
            end
            if (m1_rdata_vld[i]) begin
                vcnt[i][1] <= vcnt[i][1] + 1;
                vcyc[i][1] <= cyc;
                vdat[i][1] <= m1_rdata[i];
            end
            if (m0_err[i]) ecnt[i][0] <= ecnt[i][0] + 1;
            if (m1_err[i]) ecnt[i][1] <= ecnt[i][1] + 1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expire(input string name, input int act, input int exp);
        checks++;
        failures++;
        $display("FAIL %s: wait expired, got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_req(input int p, input logic wr, input logic rd,
                           input logic [7:0] a, input logic [7:0] d);
        if (p == 0) begin
            m0_wr_en = wr; m0_rd_en = rd; m0_addr = a; m0_wdata = d;
        end else begin
            m1_wr_en = wr; m1_rd_en = rd; m1_addr = a; m1_wdata = d;
        end
    endtask

    task automatic release_req;
        @(negedge clk);
        m0_wr_en = 0; m0_rd_en = 0; m1_wr_en = 0; m1_rd_en = 0;
    endtask

    task automatic wait_cnt(input string name, input int i, input int target,
                            input int budget);
        int n = 0;
        while (icnt[i] < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (icnt[i] < target) expire(name, icnt[i], target);
    endtask

    task automatic wait_rdy(input string name, input int i, input int p,
                            input int budget);
        int n = 0;
        while (((p == 0) ? m0_rdy[i] : m1_rdy[i]) !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (((p == 0) ? m0_rdy[i] : m1_rdy[i]) !== 1'b1) expire(name, 0, 1);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic       port;
        logic       wr;
        logic       rd;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rsp;
        logic       exp_rd;
        int         exp_v0;
        int         exp_v1;
    } vec_t;

    vec_t vt[5];

    initial begin
        int b0, b1, d0, rc, e1, n;
        vt[0] = '{1'b0, 1'b1, 1'b0, 8'h12, 8'h80, 8'h00, 1'b0, 0, 0};
        vt[1] = '{1'b1, 1'b0, 1'b1, 8'h0B, 8'h00, 8'h73, 1'b1, 0, 1};
        vt[2] = '{1'b0, 1'b0, 1'b1, 8'h0A, 8'h00, 8'h5C, 1'b1, 1, 0};
        vt[3] = '{1'b1, 1'b1, 1'b1, 8'h3A, 8'h44, 8'hE1, 1'b0, 0, 0};
        vt[4] = '{1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'h00, 1'b0, 0, 0};

        tick(2);
        chk("rst_m0_rdy", m0_rdy[0], 1);
        chk("rst_m1_rdy", m1_rdy[0], 1);
        chk("rst_busy", busy[0], 0);
        chk("rst_owner", owner[0], 0);
        chk("rst_s_en", {s_wr_en[0], s_rd_en[0]}, 0);
        chk("rst_s_fields", {s_addr[0], s_wdata[0]}, 0);
        chk("rst_rdata", {m0_rdata[0], m1_rdata[0]}, 0);
        chk("rst_pulses", {m0_rdata_vld[0], m1_rdata_vld[0], m0_err[0], m1_err[0]}, 0);
        rst = 1'b0;
        tick(2);

        for (int k = 0; k < 5; k++) begin
            int p;
            int vb0, vb1;
            p   = int'(vt[k].port);
            b0  = icnt[0];
            vb0 = vcnt[0][0];
            vb1 = vcnt[0][1];
            rsp = vt[k].rsp;
            rc  = cyc;
            set_req(p, vt[k].wr, vt[k].rd, vt[k].addr, vt[k].wdata);
            release_req();
            chk($sformatf("v%0d_rdy_low", k), (p == 0) ? m0_rdy[0] : m1_rdy[0], 0);
            wait_cnt($sformatf("v%0d_issue", k), 0, b0 + 1, 20);
            chk($sformatf("v%0d_latency", k), ilog[0][b0].cyc - rc, 2);
            chk($sformatf("v%0d_op", k), ilog[0][b0].rd, vt[k].exp_rd);
            chk($sformatf("v%0d_addr", k), ilog[0][b0].addr, vt[k].addr);
            if (!vt[k].exp_rd)
                chk($sformatf("v%0d_wdata", k), ilog[0][b0].wdata, vt[k].wdata);
            wait_rdy($sformatf("v%0d_done", k), 0, p, 40);
            chk($sformatf("v%0d_rdy_rise", k), cyc, dlog[0][dcnt[0] - 1] + 1);
            tick(2);
            chk($sformatf("v%0d_once", k), icnt[0] - b0, 1);
            chk($sformatf("v%0d_vld0", k), vcnt[0][0] - vb0, vt[k].exp_v0);
            chk($sformatf("v%0d_vld1", k), vcnt[0][1] - vb1, vt[k].exp_v1);
            if (vt[k].exp_v0 + vt[k].exp_v1 != 0) begin
                chk($sformatf("v%0d_rdata", k), vdat[0][p], vt[k].rsp);
                chk($sformatf("v%0d_vld_cyc", k), vcyc[0][p], dlog[0][dcnt[0] - 1] + 1);
            end
        end

        // Simultaneous requests: RR instance favours port 1, fixed favours 0.
        do_reset();
        b0 = icnt[0];
        b1 = icnt[1];
        d0 = dcnt[0];
        rsp = 8'h99;
        rc = cyc;
        set_req(0, 1'b1, 1'b0, 8'h11, 8'h01);
        set_req(1, 1'b0, 1'b1, 8'h0A, 8'h00);
        release_req();
        wait_cnt("sim_rr_two", 0, b0 + 2, 60);
        wait_cnt("sim_fp_two", 1, b1 + 2, 60);
        tick(lat + 8);
        chk("sim_rr_first", {ilog[0][b0].rd, ilog[0][b0].addr}, {1'b1, 8'h0A});
        chk("sim_rr_second", {ilog[0][b0 + 1].rd, ilog[0][b0 + 1].addr}, {1'b0, 8'h11});
        chk("sim_rr_count", icnt[0] - b0, 2);
        chk("sim_rr_latency", ilog[0][b0].cyc - rc, 2);
        chk("sim_rr_b2b", ilog[0][b0 + 1].cyc, dlog[0][d0] + 2);
        chk("sim_fp_first", {ilog[1][b1].rd, ilog[1][b1].addr}, {1'b0, 8'h11});
        chk("sim_fp_second", {ilog[1][b1 + 1].rd, ilog[1][b1 + 1].addr}, {1'b1, 8'h0A});
        chk("sim_fp_count", icnt[1] - b1, 2);

        // Lock: two m1 reads back to back while m0 waits.
        do_reset();
        b0 = icnt[0];
        m1_lock = 1'b1;
        set_req(1, 1'b0, 1'b1, 8'h20, 8'h00);
        set_req(0, 1'b1, 1'b0, 8'h30, 8'h31);
        release_req();
        wait_rdy("lk_m1a_done", 0, 1, 60);
        set_req(1, 1'b0, 1'b1, 8'h21, 8'h00);
        release_req();
        wait_rdy("lk_m1b_done", 0, 1, 60);
        tick(3);
        chk("lk_hold", icnt[0] - b0, 2);
        chk("lk_m0_waiting", m0_rdy[0], 0);
        m1_lock = 1'b0;
        wait_cnt("lk_m0_issue", 0, b0 + 3, 60);
        chk("lk_first", ilog[0][b0].addr, 8'h20);
        chk("lk_second", ilog[0][b0 + 1].addr, 8'h21);
        chk("lk_third", {ilog[0][b0 + 2].rd, ilog[0][b0 + 2].addr}, {1'b0, 8'h30});
        wait_rdy("lk_m0_done", 0, 0, 40);

        // Timeout: master stalls, m0 aborts, queued m1 follows.
        do_reset();
        b0 = icnt[0];
        e1 = ecnt[0][1];
        hang = 1'b1;
        set_req(0, 1'b1, 1'b0, 8'h55, 8'h66);
        release_req();
        wait_cnt("to_issue", 0, b0 + 1, 20);
        set_req(1, 1'b1, 1'b0, 8'h77, 8'h88);
        release_req();
        chk("to_m1_pending", m1_rdy[0], 0);
        n = 0;
        while (m0_err[0] !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (m0_err[0] !== 1'b1) begin
            expire("to_err_seen", 0, 1);
        end else begin
            chk("to_err_cyc", cyc - ilog[0][b0].cyc, 21);
            chk("to_m0_rdy", m0_rdy[0], 1);
            tick(1);
            chk("to_err_width", m0_err[0], 0);
            chk("to_idle", busy[0], 0);
        end
        hang = 1'b0;
        wait_cnt("to_next", 0, b0 + 2, 40);
        chk("to_next_addr", ilog[0][b0 + 1].addr, 8'h77);
        chk("to_owner", owner[0], 1);
        chk("to_m1_no_err", ecnt[0][1] - e1, 0);
        wait_rdy("to_m1_done", 0, 1, 40);

        // Reset while the master is busy with an m1 read.
        do_reset();
        lat = 6;
        rsp = 8'h3C;
        b0 = icnt[0];
        b1 = vcnt[0][1];
        set_req(1, 1'b0, 1'b1, 8'h40, 8'h00);
        release_req();
        wait_cnt("mr_issue", 0, b0 + 1, 20);
        tick(2);
        chk("mr_busy", busy[0], 1);
        chk("mr_owner", owner[0], 1);
        rst = 1'b1;
        tick(1);
        chk("mr_s_en", {s_wr_en[0], s_rd_en[0]}, 0);
        chk("mr_busy_clr", busy[0], 0);
        chk("mr_owner_clr", owner[0], 0);
        chk("mr_rdy", {m0_rdy[0], m1_rdy[0]}, 2'b11);
        chk("mr_s_fields", {s_addr[0], s_wdata[0]}, 0);
        chk("mr_pulses", {m1_rdata_vld[0], m1_err[0]}, 0);
        rst = 1'b0;
        b0 = icnt[0];
        tick(15);
        chk("mr_no_issue", icnt[0] - b0, 0);
        chk("mr_no_vld", vcnt[0][1] - b1, 0);
        lat = 3;
        rc = cyc;
        set_req(0, 1'b1, 1'b0, 8'h01, 8'h02);
        release_req();
        wait_cnt("mr_new_issue", 0, b0 + 1, 20);
        chk("mr_new_latency", ilog[0][b0].cyc - rc, 2);
        wait_rdy("mr_new_done", 0, 0, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
